// File: rtl/shift_reg_param.sv
// Multi-step shift/rotate register: a command is latched on start and applied
// one bit-step per enabled clock, with busy/done handshake to the issuer.
module shift_reg_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [2:0]       shift_direction,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_LOAD = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [2:0]       dir_q, dir_d;
  logic [AMT_W-1:0] rem_q, rem_d;

  logic             accept;
  logic             cmd_multi;
  logic             step_en;
  logic [2:0]       step_op;
  logic [WIDTH:0]   step_res;

  function automatic logic is_shift(input logic [2:0] op);
    return (op != OP_HOLD) && (op != OP_LOAD) && (op != OP_CLR);
  endfunction

  // One bit-step; result is {bit leaving the register, new register value}.
  function automatic logic [WIDTH:0] do_step(input logic [2:0] op,
                                             input logic [WIDTH-1:0] d,
                                             input logic sin);
    logic [WIDTH:0] r;
    case (op)
      OP_SLL:  r = {d[WIDTH-1], d[WIDTH-2:0], sin};
      OP_SRL:  r = {d[0], sin, d[WIDTH-1:1]};
      OP_SRA:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

  assign accept    = (state_q == IDLE) && enable && start;
  assign cmd_multi = is_shift(shift_direction) && (shift_amt > AMT_W'(1));
  assign step_op   = (state_q == RUN) ? dir_q : shift_direction;
  assign step_res  = do_step(step_op, data_q, serial_in);
  assign step_en   = ((state_q == RUN) && enable) ||
                     (accept && is_shift(shift_direction) && (shift_amt != '0));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && cmd_multi) state_d = RUN;
      RUN:  if (enable && (rem_q == AMT_W'(1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake next values
  always_comb begin
    data_d = data_q;
    sout_d = sout_q;
    dir_d  = dir_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    if (step_en) {sout_d, data_d} = step_res;
    if (accept) begin
      dir_d = shift_direction;
      if (shift_direction == OP_LOAD) data_d = data_in;
      if (shift_direction == OP_CLR)  data_d = '0;
      if (cmd_multi) rem_d = shift_amt - AMT_W'(1);
      else           done_d = 1'b1;
    end else if ((state_q == RUN) && enable) begin
      rem_d  = rem_q - AMT_W'(1);
      done_d = (rem_q == AMT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      sout_q <= 1'b0;
      done_q <= 1'b0;
      dir_q  <= OP_HOLD;
      rem_q  <= '0;
    end else begin
      data_q <= data_d;
      sout_q <= sout_d;
      done_q <= done_d;
      dir_q  <= dir_d;
      rem_q  <= rem_d;
    end
  end

  // Outputs
  always_comb begin
    busy       = (state_q == RUN);
    done       = done_q;
    data_out   = data_q;
    serial_out = sout_q;
  end

endmodule

// File: tb/tb_shift_reg_param.sv
// Bench for shift_reg_param: directed scenarios with literal expectations, then
// random traffic compared every cycle against an integer-level command model.
module tb_shift_reg_param;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic [2:0] shift_direction = 3'b000;
  logic [2:0] shift_amt = 3'd0;
  logic       serial_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       serial_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;

  shift_reg_param #(.WIDTH(8), .AMT_W(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .shift_direction(shift_direction), .shift_amt(shift_amt),
    .serial_in(serial_in), .data_in(data_in), .data_out(data_out),
    .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: a command is an op plus a count of pending steps.
  int m_data = 0, m_sout = 0, m_left = 0, m_op = 0, m_done = 0;

  task automatic m_step(input int op, input int sin);
    int d;
    d = m_data;
    case (op)
      1: begin m_sout = d / 128;  m_data = (d * 2 + sin) % 256; end
      2: begin m_sout = d % 2;    m_data = d / 2 + sin * 128; end
      3: begin m_sout = d % 2;    m_data = d / 2 + (d / 128) * 128; end
      4: begin m_sout = d / 128;  m_data = (d * 2) % 256 + d / 128; end
      5: begin m_sout = d % 2;    m_data = d / 2 + (d % 2) * 128; end
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      m_data = 0; m_sout = 0; m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_done = 0;
      if (enable) begin
        m_step(m_op, int'(serial_in));
        m_left = m_left - 1;
        m_done = (m_left == 0);
      end
    end else begin
      m_done = 0;
      if (enable && start) begin
        m_op = int'(shift_direction);
        if (m_op == 6) m_data = int'(data_in);
        else if (m_op == 7) m_data = 0;
        if (m_op >= 1 && m_op <= 5 && shift_amt != 0) begin
          m_step(m_op, int'(serial_in));
          m_left = int'(shift_amt) - 1;
        end
        m_done = (m_left == 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      chk("model data_out", int'(data_out), m_data);
      chk("model serial_out", int'(serial_out), m_sout);
      chk("model busy", int'(busy), int'(m_left > 0));
      chk("model done", int'(done), m_done);
      if (busy && done) chk("busy&done exclusive", 1, 0);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [2:0] amt,
                       input logic [7:0] din, input logic sin);
    enable = 1'b1; start = 1'b1; shift_direction = op;
    shift_amt = amt; data_in = din; serial_in = sin;
    @(negedge clk);
    start = 1'b0; shift_direction = 3'b000; shift_amt = 3'd0; data_in = 8'h00;
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    armed = 1'b1;
    reset = 1'b1;
    chk("reset data_out", int'(data_out), 0);
    chk("reset serial_out", int'(serial_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);

    issue(3'b110, 3'd0, 8'hA5, 1'b0);
    chk("load data", int'(data_out), 'hA5);
    chk("load done", int'(done), 1);
    chk("load busy", int'(busy), 0);
    @(negedge clk);
    chk("load done 1 cycle", int'(done), 0);

    issue(3'b100, 3'd3, 8'h00, 1'b0);
    chk("rol busy c1", int'(busy), 1);
    @(negedge clk);
    chk("rol busy c2", int'(busy), 1);
    chk("rol no early done", int'(done), 0);
    @(negedge clk);
    chk("rol data", int'(data_out), 'h2D);
    chk("rol done", int'(done), 1);
    chk("rol busy clr", int'(busy), 0);
    chk("rol serial_out", int'(serial_out), 1);

    issue(3'b110, 3'd0, 8'h80, 1'b0);
    issue(3'b011, 3'd2, 8'h00, 1'b0);
    chk("sra step1", int'(data_out), 'hC0);
    enable = 1'b0;
    @(negedge clk);
    chk("sra stall data", int'(data_out), 'hC0);
    chk("sra stall busy", int'(busy), 1);
    chk("sra stall done", int'(done), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("sra data", int'(data_out), 'hE0);
    chk("sra done", int'(done), 1);

    issue(3'b111, 3'd0, 8'h00, 1'b0);
    issue(3'b001, 3'd7, 8'h00, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; shift_direction = 3'b110; data_in = 8'hFF; shift_amt = 3'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("sll data", int'(data_out), 'h7F);
    chk("sll serial_out", int'(serial_out), 0);
    chk("sll done", int'(done), 1);

    issue(3'b101, 3'd5, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort data", int'(data_out), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    @(negedge clk);
    chk("abort no done", int'(done), 0);
    issue(3'b110, 3'd0, 8'h3C, 1'b0);
    chk("post-reset load", int'(data_out), 'h3C);
    chk("post-reset done", int'(done), 1);

    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 99) != 0);
      enable          = ($urandom_range(0, 99) < 80);
      start           = ($urandom_range(0, 99) < 35);
      shift_direction = 3'($urandom_range(0, 7));
      shift_amt       = 3'($urandom_range(0, 7));
      serial_in       = 1'($urandom_range(0, 1));
      data_in         = 8'($urandom_range(0, 255));
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_reg_param.md
SHIFT_REG_PARAM -- requirements
Module: shift_reg_param

Interface
REQ-001 Parameter WIDTH, default 8, is the register width in bits; legal range is 2 or more.
REQ-002 Parameter AMT_W, default 3, is the width of the shift-amount field in bits.
REQ-003 The block SHALL have one clock and a synchronous active-low reset. Port `reset` is active-low and synchronous; there is no other clock or reset.
REQ-004 Port clk: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 Port reset: input, 1 bit, synchronous active-low reset.
REQ-006 Port enable: input, 1 bit, global advance qualifier.
REQ-007 Port start: input, 1 bit, command strobe.
REQ-008 Port shift_direction: input, 3 bits, operation code for the command.
REQ-009 Port shift_amt: input, AMT_W bits, number of 1-bit steps for a shift command.
REQ-010 Port serial_in: input, 1 bit, fill bit for logical shifts.
REQ-011 Port data_in: input, WIDTH bits, parallel load value.
REQ-012 Port data_out: output, WIDTH bits, register contents (registered).
REQ-013 Port serial_out: output, 1 bit, last bit shifted or rotated out (registered).
REQ-014 Port busy: output, 1 bit, high while a multi-step command is in progress.
REQ-015 Port done: output, 1 bit, one-cycle completion pulse.

Function
REQ-016 The shift_direction encoding SHALL be as follows:
- 000: hold.
- 001: shift left logical; serial_in enters bit 0.
- 010: shift right logical; serial_in enters bit WIDTH-1.
- 011: shift right arithmetic; the MSB is replicated.
- 100: rotate left.
- 101: rotate right.
- 110: load data_in.
- 111: clear to all zeros.
REQ-017 A command is accepted on a rising edge where reset=1, enable=1, start=1 and the FSM is in IDLE. On acceptance, shift_direction and shift_amt SHALL be latched internally.
REQ-018 The FSM SHALL have two states, IDLE and RUN; reset forces IDLE.
REQ-019 Hold, load, clear, and any shift with shift_amt=0 SHALL complete on the accepting edge:
- data_out is updated on that edge (unchanged for hold or amt=0);
- busy stays 0;
- done=1 for the following cycle only.
REQ-020 A shift or rotate with shift_amt=N≥1 SHALL work as follows:
- the accepting edge performs step 1;
- each later enabled edge performs one further step until N steps are done;
- busy=1 from after the accepting edge until after the edge of step N, then busy=0;
- when N=1, busy never asserts;
- done=1 for exactly the one cycle following the step-N edge.
REQ-021 With no stalls, a command with N≥1 SHALL finish with its result on data_out N edges after acceptance, counting the accepting edge as edge 1.
REQ-022 In RUN with enable=0, the block SHALL stall: no step is taken, the remaining count and busy are held, and done stays 0.
REQ-023 start during RUN SHALL be ignored, with no effect on the latched command or state.
REQ-024 Changes to shift_direction or shift_amt after acceptance SHALL have no effect on the command in progress.
REQ-025 serial_in SHALL be sampled on each step edge, not latched at acceptance.
REQ-026 On each shift or rotate step, serial_out SHALL take the bit leaving data_out: bit WIDTH-1 for left operations, bit 0 for right operations. serial_out holds its value otherwise.
REQ-027 shift_amt ≥ WIDTH is legal and SHALL perform exactly shift_amt steps: rotates wrap modulo WIDTH, and logical shifts fill entirely with serial_in.
REQ-028 With enable=0 in IDLE, nothing SHALL change and start is ignored.
REQ-029 done and busy SHALL never be high in the same cycle.

Reset
REQ-030 On a rising edge with reset=0, the block SHALL set data_out=0, serial_out=0, busy=0, done=0, FSM=IDLE and remaining count=0, regardless of enable, start or the current state.
REQ-031 Reset asserted mid-command SHALL abort the command with no done pulse; the first command after release is accepted normally.

Verification (WIDTH=8, AMT_W=3)
REQ-032 Hold reset=0 for 2 edges, then release -> data_out=0x00, serial_out=0, busy=0, done=0.
REQ-033 Load (110) with data_in=0xA5 and start for 1 cycle -> next cycle data_out=0xA5 and done=1 for 1 cycle; busy stays 0.
REQ-034 From 0xA5, rotate left (100) with amt=3 -> busy=1 for 2 cycles; data_out=0x2D after the 3rd edge; done=1 for 1 cycle; serial_out=1.
REQ-035 From 0x80, arithmetic shift right (011) with amt=2 and enable=0 for one cycle mid-command -> 3 edges to finish; data_out=0xE0; done=1 once.
REQ-036 From 0x00, logical shift left (001) with amt=7 and serial_in=1 -> data_out=0x7F and serial_out=0 after 7 edges; a start pulse issued during busy is ignored.
REQ-037 Reset=0 asserted during rotate right (101) with amt=5, after 2 steps -> data_out=0x00, busy=0, no done pulse; a following load of 0x3C completes normally.
